// File: rtl/jk_cmd_sequencer.sv
// Command sequencer that drives a downstream JK flip-flop with {j,k} for a counted number of cycles.
// Optional macro JK_SHADOW_CHECK_EN adds a shadow Q model and a sticky err flag on q_in mismatch.
module jk_cmd_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    output logic             j,
    output logic             k,
    input  logic             q_in,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             j_q, j_d;
    logic             k_q, k_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 2'b00;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    // j/k are registered from the next state so the first drive cycle follows acceptance directly.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        {j_d, k_d} = 2'b00;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_cnt != '0) begin
                        state_d    = DRIVE;
                        cnt_d      = cmd_cnt;
                        op_d       = cmd_op;
                        {j_d, k_d} = cmd_op;
                    end else begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end
                end
            end
            DRIVE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end else begin
                    {j_d, k_d} = op_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign j         = j_q;
    assign k         = k_q;

`ifdef JK_SHADOW_CHECK_EN
    logic shadow_q;
    logic err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= (j_q & ~shadow_q) | (~k_q & shadow_q);
            if (q_in != shadow_q) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    logic unused_q_in;
    assign unused_q_in = q_in;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Randomized and directed bench for jk_cmd_sequencer with a downstream JK flip-flop model and
// expected behaviour derived from command semantics (drive length, done timing, resulting Q).
module tb_jk_cmd_sequencer;

    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic             j, k;
    logic             q_in;
    logic             busy, done, err;

    logic q_ff;
    logic corrupt;
    logic exp_q;
    logic exp_err_on_glitch;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    jk_cmd_sequencer #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .j         (j),
        .k         (k),
        .q_in      (q_in),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Downstream JK flip-flop on the same clock and reset.
    always @(posedge clk) begin
        if (reset) q_ff <= 1'b0;
        else begin
            case ({j, k})
                2'b01:   q_ff <= 1'b0;
                2'b10:   q_ff <= 1'b1;
                2'b11:   q_ff <= ~q_ff;
                default: q_ff <= q_ff;
            endcase
        end
    end

    assign q_in = q_ff ^ corrupt;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller is at #1 after an edge with the DUT in IDLE. Returns at #1 in the IDLE cycle after done.
    task automatic do_cmd(input logic [1:0] op, input logic [CNT_W-1:0] cnt, input bit hold);
        int n;
        n = int'(cnt);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = cnt;
        chk("accept_ready", 8'(cmd_ready), 8'd1);
        step();
        if (!hold) cmd_valid = 1'b0;
        for (int i = 1; i <= n; i++) begin
            cmd_op  = 2'($urandom);
            cmd_cnt = CNT_W'($urandom);
            chk("drv_j", 8'(j), 8'(op[1]));
            chk("drv_k", 8'(k), 8'(op[0]));
            chk("drv_busy", 8'(busy), 8'd1);
            chk("drv_done", 8'(done), 8'd0);
            chk("drv_ready", 8'(cmd_ready), 8'd0);
            step();
        end
        cmd_op  = 2'($urandom);
        cmd_cnt = CNT_W'($urandom);
        chk("done_pulse", 8'(done), 8'd1);
        chk("done_j", 8'(j), 8'd0);
        chk("done_k", 8'(k), 8'd0);
        chk("done_busy", 8'(busy), 8'd1);
        chk("done_ready", 8'(cmd_ready), 8'd0);
        step();
        if (n != 0) begin
            case (op)
                2'b10:   exp_q = 1'b1;
                2'b01:   exp_q = 1'b0;
                2'b11:   exp_q = exp_q ^ cnt[0];
                default: exp_q = exp_q;
            endcase
        end
        chk("idle_ready", 8'(cmd_ready), 8'd1);
        chk("idle_done", 8'(done), 8'd0);
        chk("idle_busy", 8'(busy), 8'd0);
        chk("idle_jk", 8'({j, k}), 8'd0);
        chk("q_after", 8'(q_ff), 8'(exp_q));
        chk("err_clean", 8'(err), 8'd0);
        $display("cmd op=%b cnt=%0d hold=%0d q=%b err=%b", op, cnt, hold, q_ff, err);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef JK_SHADOW_CHECK_EN
        exp_err_on_glitch = 1'b1;
`else
        exp_err_on_glitch = 1'b0;
`endif
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_cnt   = CNT_W'(3);
        corrupt   = 1'b0;
        exp_q     = 1'b0;
        repeat (3) step();
        chk("rst_j", 8'(j), 8'd0);
        chk("rst_k", 8'(k), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_err", 8'(err), 8'd0);
        cmd_valid = 1'b0;
        reset     = 1'b0;
        step();
        chk("post_rst_ready", 8'(cmd_ready), 8'd1);
        $display("reset done");

        // Set for 3 cycles, then clear to 0 and toggle 5 times.
        do_cmd(2'b10, CNT_W'(3), 1'b0);
        chk("set_q1", 8'(q_ff), 8'd1);
        do_cmd(2'b01, CNT_W'(1), 1'b0);
        do_cmd(2'b11, CNT_W'(5), 1'b0);
        chk("toggle_q1", 8'(q_ff), 8'd1);

        // Zero count: straight to DONE.
        do_cmd(2'b01, CNT_W'(0), 1'b0);

        // Reset in the fourth drive cycle of a long set command.
        do_cmd(2'b01, CNT_W'(2), 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_cnt   = CNT_W'(15);
        step();
        cmd_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk("abort_drv_j", 8'(j), 8'd1);
            chk("abort_drv_k", 8'(k), 8'd0);
            if (i < 4) step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_q = 1'b0;
        chk("abort_jk", 8'({j, k}), 8'd0);
        chk("abort_busy", 8'(busy), 8'd0);
        chk("abort_done", 8'(done), 8'd0);
        chk("abort_ready", 8'(cmd_ready), 8'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_no_done", 8'(done), 8'd0);
            chk("abort_idle_jk", 8'({j, k}), 8'd0);
            chk("abort_idle_busy", 8'(busy), 8'd0);
        end
        $display("abort done q=%b", q_ff);

        // cmd_valid held across two commands.
        do_cmd(2'b10, CNT_W'(2), 1'b1);
        do_cmd(2'b01, CNT_W'(1), 1'b0);

        // Max count without wrap.
        do_cmd(2'b11, CNT_W'(CNT_MAX), 1'b0);

        // Randomized commands.
        for (int n = 0; n < 40; n++) begin
            logic [1:0]       rop;
            logic [CNT_W-1:0] rcnt;
            bit               rhold;
            rop   = 2'($urandom);
            rcnt  = CNT_W'($urandom_range(0, CNT_MAX));
            rhold = (n != 39) && ($urandom_range(0, 3) == 0);
            do_cmd(rop, rcnt, rhold);
        end

        // Glitch q_in for one cycle while idle.
        corrupt = 1'b1;
        step();
        corrupt = 1'b0;
        chk("err_glitch", 8'(err), 8'(exp_err_on_glitch));
        step();
        step();
        chk("err_sticky", 8'(err), 8'(exp_err_on_glitch));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("err_cleared", 8'(err), 8'd0);
        step();
        chk("err_after_rst", 8'(err), 8'd0);
        $display("glitch check err_expected=%b", exp_err_on_glitch);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
